instr_mem_sync: RTL and testbench

- Parametrised, clocked instruction memory for the single-cycle and pipelined datapaths.
- Replaces the fixed combinational program ROM with a writable word array:
  - self-clears to NOP after reset;
  - loaded through a program port;
  - serves fetches with one-cycle registered latency;
  - flags misaligned or out-of-range fetches.
- Sits between PC logic and decode.

---
 rtl/instr_mem_sync.sv | 150 +++++++++++++++
 tb/tb_instr_mem_sync.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_sync.sv
// instr_mem_sync: writable instruction memory with registered fetch.
// After reset the array is cleared to NOP_WORD, one word per cycle (CLEAR),
// then fetches and program writes are served (IDLE). Misaligned or
// out-of-range fetches return NOP_WORD with fault set; such program writes
// are dropped and flagged on prog_err.
// Optional build macro IMEM_PARITY_EN: per-word even parity plus a
// parity_err output.
module instr_mem_sync #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              fault,
`ifdef IMEM_PARITY_EN
    output logic              parity_err,
`endif
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_err,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    // Aligned word address whose index lies inside the array with no
    // stray upper bits.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00) && ((a >> (IDX_W + 2)) == '0);
    endfunction

    logic             fetch_ok, prog_ok, fetch_acc, prog_acc;
    logic [IDX_W-1:0] fetch_idx, prog_idx;
    logic [DATA_W-1:0] rd_data;

    assign fetch_ok  = addr_ok(address);
    assign prog_ok   = addr_ok(prog_addr);
    assign fetch_idx = address[IDX_W+1:2];
    assign prog_idx  = prog_addr[IDX_W+1:2];
    assign fetch_acc = enable && (state == IDLE);
    assign prog_acc  = prog_we && (state == IDLE);
    assign rd_data   = mem[fetch_idx];

`ifdef IMEM_PARITY_EN
    logic mem_par [DEPTH];
    logic par_bad;

    // Stored bit makes the word plus parity even; a mismatch means corruption.
    assign par_bad = (^rd_data) != mem_par[fetch_idx];
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= CLEAR;
        else       state <= state_nxt;
    end

    // Next state: leave CLEAR once the last word has been written.
    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_ptr == LAST) state_nxt = IDLE;
    end

    // Outputs decoded from state.
    always_comb begin
        busy = (state == CLEAR);
    end

    // Clear pointer: walks 0..DEPTH-1 and parks at the last index.
    always_ff @(posedge clk) begin
        if (reset)
            clr_ptr <= '0;
        else if (state == CLEAR && clr_ptr != LAST)
            clr_ptr <= clr_ptr + IDX_W'(1);
    end

    // Array write port: clear sweep has priority, then accepted program writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= NOP_WORD;
`ifdef IMEM_PARITY_EN
                mem_par[clr_ptr] <= ^NOP_WORD;
`endif
            end else if (prog_acc && prog_ok) begin
                mem[prog_idx] <= prog_data;
`ifdef IMEM_PARITY_EN
                mem_par[prog_idx] <= ^prog_data;
`endif
            end
        end
    end

    // Registered fetch; reads see pre-write contents of the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= NOP_WORD;
            out_valid <= 1'b0;
            fault     <= 1'b0;
`ifdef IMEM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (fetch_acc) begin
            out_valid <= 1'b1;
`ifdef IMEM_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (!fetch_ok) begin
                out   <= NOP_WORD;
                fault <= 1'b1;
`ifdef IMEM_PARITY_EN
            end else if (par_bad) begin
                out        <= NOP_WORD;
                fault      <= 1'b1;
                parity_err <= 1'b1;
`endif
            end else begin
                out   <= rd_data;
                fault <= 1'b0;
            end
        end else begin
            out_valid <= 1'b0;
            fault     <= 1'b0;
`ifdef IMEM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end
    end

    // Rejected program write pulse; only meaningful once the clear is done.
    always_ff @(posedge clk) begin
        if (reset) prog_err <= 1'b0;
        else       prog_err <= prog_acc && !prog_ok;
    end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Scoreboard bench for instr_mem_sync: fetches push expected results,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_instr_mem_sync;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] out;
    logic        out_valid, fault;
    logic        prog_we = 1'b0;
    logic [31:0] prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic        prog_err, busy;
`ifdef IMEM_PARITY_EN
    logic        parity_err;
`endif

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic        flt;
        logic        perr;
    } exp_t;
    exp_t q[$];

    instr_mem_sync dut (
        .clk(clk), .reset(reset), .enable(enable), .address(address),
        .out(out), .out_valid(out_valid), .fault(fault),
`ifdef IMEM_PARITY_EN
        .parity_err(parity_err),
`endif
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_err(prog_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Monitor: every presented result must match the oldest expectation.
    always @(negedge clk) begin
        if (mon_en && out_valid) begin
            exp_t e;
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid: out=%h fault=%b, no fetch expected", out, fault);
            end else begin
                e = q.pop_front();
`ifdef IMEM_PARITY_EN
                if (out !== e.data || fault !== e.flt || parity_err !== e.perr) begin
                    fails++;
                    $display("FAIL fetch: got %h/%b/%b want %h/%b/%b", out, fault, parity_err, e.data, e.flt, e.perr);
                end
`else
                if (out !== e.data || fault !== e.flt) begin
                    fails++;
                    $display("FAIL fetch: got %h/%b want %h/%b", out, fault, e.data, e.flt);
                end
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic f, input logic p);
        enable  = 1'b1;
        address = a;
        q.push_back('{d, f, p});
        tick();
        enable = 1'b0;
    endtask

    task automatic prog(input logic [31:0] a, input logic [31:0] d, input logic want_err);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we = 1'b0;
        check("prog_err", {31'b0, prog_err}, {31'b0, want_err});
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        // Reset with a fetch held on address 0 throughout.
        enable  = 1'b1;
        address = '0;
        tick();
        mon_en = 1'b1;
        check("rst_out", out, NOP);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        check("rst_prog_err", {31'b0, prog_err}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        count_busy(n);
        check("clear_cycles", n, 32'd64);
        for (int i = 0; i < 6; i++) fetch(32'h0, NOP, 1'b0, 1'b0);

        // Program three words and fetch them back to back.
        prog(32'h0, 32'h00300093, 1'b0);
        prog(32'h4, 32'h00700113, 1'b0);
        prog(32'h8, 32'h001101B3, 1'b0);
        fetch(32'h0, 32'h00300093, 1'b0, 1'b0);
        fetch(32'h4, 32'h00700113, 1'b0, 1'b0);
        fetch(32'h8, 32'h001101B3, 1'b0, 1'b0);

        // Misaligned and out-of-range fetches.
        fetch(32'h6, NOP, 1'b1, 1'b0);
        fetch(32'h100, NOP, 1'b1, 1'b0);

        // Rejected program write aliases index 0 if it were wrongly taken.
        prog(32'h102, 32'hDEADBEEF, 1'b1);
        tick();
        check("prog_err_clear", {31'b0, prog_err}, 32'd0);
        fetch(32'h0, 32'h00300093, 1'b0, 1'b0);

        // Read-before-write on the same word.
        enable    = 1'b1;
        address   = 32'h10;
        prog_we   = 1'b1;
        prog_addr = 32'h10;
        prog_data = 32'h12345678;
        q.push_back('{NOP, 1'b0, 1'b0});
        tick();
        prog_we = 1'b0;
        enable  = 1'b0;
        fetch(32'h10, 32'h12345678, 1'b0, 1'b0);

`ifdef IMEM_PARITY_EN
        // Corrupt one stored bit and expect the parity fault, then a clean fetch.
        dut.mem[3][0] = ~dut.mem[3][0];
        fetch(32'hC, NOP, 1'b1, 1'b1);
        fetch(32'h4, 32'h00700113, 1'b0, 1'b0);
`endif
        tick();

        // Reset partway into a clear restarts the full sweep.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy(n);
        check("clear_restart_cycles", n, 32'd64);
        fetch(32'h0, NOP, 1'b0, 1'b0);
        fetch(32'h4, NOP, 1'b0, 1'b0);
        fetch(32'h8, NOP, 1'b0, 1'b0);
        fetch(32'h10, NOP, 1'b0, 1'b0);
        tick();
        tick();
        check("pending_expectations", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
